// File: rtl/alarm_unit_if.sv
// alarm_unit_if: bundle of live-time, user-pulse and alarm-status signals between the clock core and the alarm unit
//   i_sec_tick        one-clk seconds pulse, live time valid in the same cycle
//   i_sec/min/hou     live binary time
//   i_set/pos/inc     set-mode controls (enter/exit, field toggle, increment)
//   i_arm/snooze/stop arm toggle, snooze and dismiss pulses
//   o_alm_min/hou     stored alarm time
//   o_setting/field   set-mode flag and edited field (0 = min, 1 = hour)
//   o_armed/ringing   alarm status flags
//   o_buzz            buzzer square wave
interface alarm_unit_if;
    logic       i_sec_tick;
    logic [5:0] i_sec;
    logic [5:0] i_min;
    logic [5:0] i_hou;
    logic       i_set;
    logic       i_pos;
    logic       i_inc;
    logic       i_arm;
    logic       i_snooze;
    logic       i_stop;
    logic [5:0] o_alm_min;
    logic [5:0] o_alm_hou;
    logic       o_setting;
    logic       o_field;
    logic       o_armed;
    logic       o_ringing;
    logic       o_buzz;
    modport master (
        output i_sec_tick, i_sec, i_min, i_hou, i_set, i_pos, i_inc, i_arm, i_snooze, i_stop,
        input  o_alm_min, o_alm_hou, o_setting, o_field, o_armed, o_ringing, o_buzz
    );
    modport slave (
        input  i_sec_tick, i_sec, i_min, i_hou, i_set, i_pos, i_inc, i_arm, i_snooze, i_stop,
        output o_alm_min, o_alm_hou, o_setting, o_field, o_armed, o_ringing, o_buzz
    );
endinterface

// File: rtl/alarm_unit.sv
// alarm_unit: alarm time store, live-time compare and ring/snooze FSM with square-wave buzzer
//   clk    system clock
//   rst_n  synchronous reset, active high despite the name
//   bus    alarm_unit_if.slave: live time and tick, user pulses in; alarm time, flags and buzzer out
module alarm_unit #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int TONE_DIV   = 25000,
    parameter int RST_HOU    = 7,
    parameter int RST_MIN    = 0
) (
    input logic         clk,
    input logic         rst_n,
    alarm_unit_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SET    = 3'd1;
    localparam logic [2:0] ARMED  = 3'd2;
    localparam logic [2:0] RING   = 3'd3;
    localparam logic [2:0] SNOOZE = 3'd4;
    localparam logic [8:0]  RING_MAX = 9'(RING_SEC - 1);
    localparam logic [8:0]  SNZ_MAX  = 9'(SNOOZE_SEC - 1);
    localparam logic [15:0] TONE_MAX = 16'(TONE_DIV - 1);

    logic [2:0]  state, state_n;
    logic [5:0]  alm_min, alm_min_n;
    logic [5:0]  alm_hou, alm_hou_n;
    logic        field, field_n;
    logic        armed_save, armed_save_n;
    logic [8:0]  sec_cnt, sec_cnt_n;
    logic [15:0] tone_cnt, tone_cnt_n;
    logic        buzz, buzz_n;
    logic        match;
    logic        ring_run;

    // Only the top-of-minute tick can match, so a dismissed alarm cannot re-fire in the same minute
    assign match = bus.i_sec_tick && bus.i_sec == 6'd0 && bus.i_min == alm_min && bus.i_hou == alm_hou;

    always_comb begin
        state_n      = state;
        alm_min_n    = alm_min;
        alm_hou_n    = alm_hou;
        field_n      = field;
        armed_save_n = armed_save;
        sec_cnt_n    = sec_cnt;
        case (state)
            IDLE: begin
                if (bus.i_set) begin
                    state_n      = SET;
                    armed_save_n = 1'b0;
                end else if (bus.i_arm) state_n = ARMED;
            end
            ARMED: begin
                if (bus.i_set) begin
                    state_n      = SET;
                    armed_save_n = 1'b1;
                end else if (bus.i_arm) state_n = IDLE;
                else if (match) begin
                    state_n   = RING;
                    sec_cnt_n = 9'd0;
                end
            end
            SET: begin
                if (bus.i_set) begin
                    state_n = armed_save ? ARMED : IDLE;
                    field_n = 1'b0;
                end else if (bus.i_pos) field_n = ~field;
                else if (bus.i_inc) begin
                    if (field) alm_hou_n = alm_hou == 6'd23 ? 6'd0 : alm_hou + 6'd1;
                    else alm_min_n = alm_min == 6'd59 ? 6'd0 : alm_min + 6'd1;
                end
            end
            RING: begin
                if (bus.i_stop) state_n = ARMED;
                else if (bus.i_snooze) begin
                    state_n   = SNOOZE;
                    sec_cnt_n = 9'd0;
                end else if (bus.i_arm) state_n = IDLE;
                else if (bus.i_sec_tick) begin
                    if (sec_cnt == RING_MAX) state_n = ARMED;
                    sec_cnt_n = sec_cnt + 9'd1;
                end
            end
            SNOOZE: begin
                if (bus.i_stop) state_n = ARMED;
                else if (bus.i_arm) state_n = IDLE;
                else if (bus.i_sec_tick) begin
                    if (sec_cnt == SNZ_MAX) begin
                        state_n   = RING;
                        sec_cnt_n = 9'd0;
                    end else sec_cnt_n = sec_cnt + 9'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Tone runs only while RING persists; any exit zeroes counter and buzzer with the state change
    assign ring_run   = state == RING && state_n == RING;
    assign tone_cnt_n = ring_run ? (tone_cnt == TONE_MAX ? 16'd0 : tone_cnt + 16'd1) : 16'd0;
    assign buzz_n     = ring_run ? buzz ^ (tone_cnt == TONE_MAX) : 1'b0;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= IDLE;
            alm_min    <= 6'(RST_MIN);
            alm_hou    <= 6'(RST_HOU);
            field      <= 1'b0;
            armed_save <= 1'b0;
            sec_cnt    <= 9'd0;
            tone_cnt   <= 16'd0;
            buzz       <= 1'b0;
        end else begin
            state      <= state_n;
            alm_min    <= alm_min_n;
            alm_hou    <= alm_hou_n;
            field      <= field_n;
            armed_save <= armed_save_n;
            sec_cnt    <= sec_cnt_n;
            tone_cnt   <= tone_cnt_n;
            buzz       <= buzz_n;
        end
    end

    assign bus.o_alm_min = alm_min;
    assign bus.o_alm_hou = alm_hou;
    assign bus.o_setting = state == SET;
    assign bus.o_field   = field;
    assign bus.o_armed   = state == ARMED || state == RING || state == SNOOZE;
    assign bus.o_ringing = state == RING;
    assign bus.o_buzz    = buzz;
endmodule

// File: tb/tb_alarm_unit.sv
// tb_alarm_unit: scoreboard bench for alarm_unit with a behavioural model, directed scenarios and random pulses
module tb_alarm_unit;
    localparam int TD  = 40;
    localparam int RS  = 60;
    localparam int SS  = 300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    alarm_unit_if bus();

    alarm_unit #(.RING_SEC(RS), .SNOOZE_SEC(SS), .TONE_DIV(TD), .RST_HOU(7), .RST_MIN(0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_SET, M_ARMED, M_RING, M_SNOOZE} mode_t;
    typedef struct {
        int amin, ahou, setting, field, armed, ringing, buzz;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    mode_t md = M_IDLE;
    int am = 0, ah = 7, fld = 0, sav = 0, ticks = 0, ring_cyc = 0;
    int th = 0, tm = 0, ts = 0;

    task automatic cmp(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp("alm_min", int'(bus.o_alm_min), e.amin);
            cmp("alm_hou", int'(bus.o_alm_hou), e.ahou);
            cmp("setting", int'(bus.o_setting), e.setting);
            cmp("field", int'(bus.o_field), e.field);
            cmp("armed", int'(bus.o_armed), e.armed);
            cmp("ringing", int'(bus.o_ringing), e.ringing);
            cmp("buzz", int'(bus.o_buzz), e.buzz);
        end
    end

    task automatic model(input bit tk, st, ps, ic, ar, sn, sp, rs);
        mode_t pm;
        exp_t e;
        pm = md;
        if (rs) begin
            md = M_IDLE; am = 0; ah = 7; fld = 0; sav = 0; ticks = 0;
        end else begin
            case (md)
                M_IDLE:   if (st) begin md = M_SET; sav = 0; end else if (ar) md = M_ARMED;
                M_ARMED:  if (st) begin md = M_SET; sav = 1; end
                          else if (ar) md = M_IDLE;
                          else if (tk && th == ah && tm == am && ts == 0) begin md = M_RING; ticks = 0; end
                M_SET:    if (st) begin md = sav ? M_ARMED : M_IDLE; fld = 0; end
                          else if (ps) fld = 1 - fld;
                          else if (ic) begin if (fld) ah = (ah + 1) % 24; else am = (am + 1) % 60; end
                M_RING:   if (sp) md = M_ARMED;
                          else if (sn) begin md = M_SNOOZE; ticks = 0; end
                          else if (ar) md = M_IDLE;
                          else if (tk) begin ticks++; if (ticks == RS) md = M_ARMED; end
                M_SNOOZE: if (sp) md = M_ARMED;
                          else if (ar) md = M_IDLE;
                          else if (tk) begin ticks++; if (ticks == SS) begin md = M_RING; ticks = 0; end end
                default:  md = M_IDLE;
            endcase
        end
        ring_cyc = (!rs && pm == M_RING && md == M_RING) ? ring_cyc + 1 : 0;
        e.amin = am;
        e.ahou = ah;
        e.setting = md == M_SET;
        e.field = fld;
        e.armed = md == M_ARMED || md == M_RING || md == M_SNOOZE;
        e.ringing = md == M_RING;
        e.buzz = md == M_RING ? (ring_cyc / TD) % 2 : 0;
        q.push_back(e);
    endtask

    task automatic step(input bit tk, st, ps, ic, ar, sn, sp, rs);
        @(negedge clk);
        rst_n = rs;
        bus.i_sec_tick = tk;
        bus.i_sec = 6'(ts);
        bus.i_min = 6'(tm);
        bus.i_hou = 6'(th);
        bus.i_set = st;
        bus.i_pos = ps;
        bus.i_inc = ic;
        bus.i_arm = ar;
        bus.i_snooze = sn;
        bus.i_stop = sp;
        @(posedge clk);
        model(tk, st, ps, ic, ar, sn, sp, rs);
    endtask

    task automatic adv();
        ts++;
        if (ts == 60) begin
            ts = 0; tm++;
            if (tm == 60) begin tm = 0; th = (th + 1) % 24; end
        end
    endtask

    task automatic tick();
        adv();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ring_at(input int h, input int m);
        th = h; tm = m; ts = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.i_sec_tick = 0; bus.i_sec = 0; bus.i_min = 0; bus.i_hou = 0;
        bus.i_set = 0; bus.i_pos = 0; bus.i_inc = 0; bus.i_arm = 0; bus.i_snooze = 0; bus.i_stop = 0;
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        th = 6; tm = 59; ts = 58;
        tick();
        tick();
        idle(100);
        repeat (RS) tick();
        idle(2);
        tick();
        ring_at(7, 0);
        idle(30);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        repeat (SS) tick();
        idle(90);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        repeat (17) step(0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(2);
        th = 0; tm = 3; ts = 30;
        tick();
        ring_at(0, 3);
        idle(5);
        step(0, 0, 0, 0, 1, 1, 1, 0);
        idle(2);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        ring_at(0, 3);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        ring_at(0, 3);
        idle(50);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        idle(3);
        for (int i = 0; i < 6000; i++) begin
            bit tk, st, ps, ic, ar, sn, sp, rs;
            tk = $urandom_range(0, 3) == 0;
            st = $urandom_range(0, 79) == 0;
            ps = $urandom_range(0, 29) == 0;
            ic = $urandom_range(0, 9) == 0;
            ar = $urandom_range(0, 99) == 0;
            sn = $urandom_range(0, 59) == 0;
            sp = $urandom_range(0, 149) == 0;
            rs = $urandom_range(0, 1499) == 0;
            if (tk) begin
                if ($urandom_range(0, 9) == 0) begin
                    th = ah; tm = am;
                    ts = $urandom_range(0, 1) ? 0 : $urandom_range(1, 59);
                end else adv();
            end
            step(tk, st, ps, ic, ar, sn, sp, rs);
        end
        idle(2);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
